// File: rtl/datapath_pkg.sv
// Shared encodings for the parametrised datapath: ALU opcodes, bus_2 sources,
// flag bit positions and the sequential multiplier state encoding.
// No logic, no latency, no flow control.
package datapath_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_NOT = 4'd3,
    OP_MUL = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8
  } alu_op_e;

  typedef enum logic [1:0] {
    BUS2_ALU  = 2'd0,
    BUS2_BUS1 = 2'd1,
    BUS2_MEM  = 2'd2,
    BUS2_ZERO = 2'd3
  } bus2_sel_e;

  // Bit positions inside the {Z, N, C, V} flag word.
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add unsigned multiplier producing a 2*DATA_W product from captured operands.
// Latency: DATA_W RUN cycles after the start edge, then a one-cycle DONE state.
// No backpressure: start is ignored while running; start in DONE begins a new multiply.
module seq_multiplier
  import datapath_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic                  prod_wr,
  output logic [2*DATA_W-1:0]   prod_nxt
);

  localparam int CNT_W = $clog2(DATA_W);

  mul_state_e              state, state_nxt;
  logic [2*DATA_W-1:0]     mcand_sh;
  logic [2*DATA_W-1:0]     acc;
  logic [DATA_W-1:0]       mplier;
  logic [CNT_W-1:0]        cnt;
  logic                    last;
  logic                    accept;

  assign last     = (cnt == CNT_W'(DATA_W - 1));
  assign accept   = start && (state != MUL_RUN);
  assign prod_nxt = acc + (mplier[0] ? mcand_sh : '0);
  // The final partial sum is handed to the owner on the edge that leaves RUN.
  assign prod_wr  = (state == MUL_RUN) && last;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MUL_IDLE;
    else      state <= state_nxt;
  end

  // Next-state: DONE can restart directly so back-to-back multiplies lose no cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      MUL_IDLE: if (start) state_nxt = MUL_RUN;
      MUL_RUN:  if (last)  state_nxt = MUL_DONE;
      MUL_DONE: state_nxt = start ? MUL_RUN : MUL_IDLE;
      default:  state_nxt = MUL_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = (state == MUL_RUN);
    done = (state == MUL_DONE);
  end

  // Operand capture and one shift-add step per RUN cycle; later operand changes are not seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_sh <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
    end else if (accept) begin
      mcand_sh <= {{DATA_W{1'b0}}, a};
      mplier   <= b;
      acc      <= '0;
      cnt      <= '0;
    end else if (state == MUL_RUN) begin
      acc      <= prod_nxt;
      mcand_sh <= mcand_sh << 1;
      mplier   <= mplier >> 1;
      cnt      <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/param_datapath.sv
// Parametrised processor datapath: register file, Y/PC/IR/address/flags, ALU and multiplier.
// Latency: non-MUL ALU ops are combinational into bus_2; MUL result lands DATA_W+1 cycles after start.
// No backpressure: control must watch alu_busy/alu_done; register loads continue during a multiply.
module param_datapath
  import datapath_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int NREGS  = 4,
  localparam int SEL_W  = $clog2(NREGS) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREGS-1:0]  load_reg,
  input  logic              load_y,
  input  logic              load_pc,
  input  logic              inc_pc,
  input  logic              load_ir,
  input  logic              load_addr,
  input  logic              load_flags,
  input  logic [SEL_W-1:0]  sel_bus_1,
  input  logic [1:0]        sel_bus_2,
  input  logic [3:0]        alu_op,
  input  logic              alu_start,
  input  logic [DATA_W-1:0] mem_word,
  output logic [DATA_W-1:0] bus_1,
  output logic [DATA_W-1:0] instruction,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] pc,
  output logic [3:0]        flags,
  output logic              alu_busy,
  output logic              alu_done
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0]   regs [NREGS];
  logic [DATA_W-1:0]   y;
  logic [DATA_W-1:0]   bus_2;
  logic [DATA_W-1:0]   res;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   prod_lo;
  logic                prod_hi_nz;
  logic                c_out;
  logic                v_out;
  logic [3:0]          flag_nxt;
  logic                mul_start;
  logic                mul_wr;
  logic [2*DATA_W-1:0] mul_prod;

  assign mul_start = alu_start && (alu_op == OP_MUL);

  seq_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start    (mul_start),
    .a        (y),
    .b        (bus_1),
    .busy     (alu_busy),
    .done     (alu_done),
    .prod_wr  (mul_wr),
    .prod_nxt (mul_prod)
  );

  // bus_1 source: registers, then PC, and zero for the unused upper select codes.
  always_comb begin
    bus_1 = '0;
    if (sel_bus_1 < SEL_W'(NREGS))       bus_1 = regs[sel_bus_1[SEL_W-2:0]];
    else if (sel_bus_1 == SEL_W'(NREGS)) bus_1 = pc;
  end

  // bus_2 source select feeding every loadable register.
  always_comb begin
    case (sel_bus_2)
      BUS2_ALU:  bus_2 = res;
      BUS2_BUS1: bus_2 = bus_1;
      BUS2_MEM:  bus_2 = mem_word;
      default:   bus_2 = '0;
    endcase
  end

  assign sum  = {1'b0, y} + {1'b0, bus_1};
  assign diff = y - bus_1;

  // ALU: A = Y, B = bus_1; overflow is judged on operand and result sign bits.
  always_comb begin
    res   = '0;
    c_out = 1'b0;
    v_out = 1'b0;
    case (alu_op)
      OP_ADD: begin
        res   = sum[MSB:0];
        c_out = sum[DATA_W];
        v_out = (y[MSB] == bus_1[MSB]) && (sum[MSB] != y[MSB]);
      end
      OP_SUB: begin
        res   = diff;
        c_out = (y < bus_1);
        v_out = (y[MSB] != bus_1[MSB]) && (diff[MSB] != y[MSB]);
      end
      OP_AND: res = y & bus_1;
      OP_NOT: res = ~y;
      OP_OR:  res = y | bus_1;
      OP_XOR: res = y ^ bus_1;
      OP_SHL: begin
        res   = {y[MSB-1:0], 1'b0};
        c_out = y[MSB];
      end
      OP_SHR: begin
        res   = {1'b0, y[MSB:1]};
        c_out = y[0];
      end
      OP_MUL: begin
        res   = prod_lo;
        c_out = prod_hi_nz;
        v_out = prod_hi_nz;
      end
      default: ;
    endcase
  end

  assign flag_nxt[FLAG_Z] = (res == '0);
  assign flag_nxt[FLAG_N] = res[MSB];
  assign flag_nxt[FLAG_C] = c_out;
  assign flag_nxt[FLAG_V] = v_out;

  // General registers; several may load the same bus_2 value in one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) if (load_reg[i]) regs[i] <= bus_2;
    end
  end

  // Special registers; PC load beats increment, flags freeze while multiplying.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      y           <= '0;
      pc          <= '0;
      instruction <= '0;
      address     <= '0;
      flags       <= '0;
    end else begin
      if (load_y)                   y           <= bus_2;
      if (load_pc)                  pc          <= bus_2;
      else if (inc_pc)              pc          <= pc + DATA_W'(1);
      if (load_ir)                  instruction <= bus_2;
      if (load_addr)                address     <= bus_2;
      if (load_flags && !alu_busy)  flags       <= flag_nxt;
    end
  end

  // Product register keeps the last completed product until the next completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_lo    <= '0;
      prod_hi_nz <= 1'b0;
    end else if (mul_wr) begin
      prod_lo    <= mul_prod[DATA_W-1:0];
      prod_hi_nz <= |mul_prod[2*DATA_W-1:DATA_W];
    end
  end

endmodule

// File: tb/tb_param_datapath.sv
module tb_param_datapath;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 8-bit, 4-register instance
  logic [3:0] a_load_reg;
  logic       a_load_y, a_load_pc, a_inc_pc, a_load_ir, a_load_addr, a_load_flags;
  logic [2:0] a_sel1;
  logic [1:0] a_sel2;
  logic [3:0] a_op;
  logic       a_start;
  logic [7:0] a_mem;
  logic [7:0] a_bus1, a_instr, a_addr, a_pc;
  logic [3:0] a_flags;
  logic       a_busy, a_done;

  // 16-bit, 8-register instance
  logic [7:0]  w_load_reg;
  logic        w_load_y, w_load_pc, w_inc_pc, w_load_ir, w_load_addr, w_load_flags;
  logic [3:0]  w_sel1;
  logic [1:0]  w_sel2;
  logic [3:0]  w_op;
  logic        w_start;
  logic [15:0] w_mem;
  logic [15:0] w_bus1, w_instr, w_addr, w_pc;
  logic [3:0]  w_flags;
  logic        w_busy, w_done;

  param_datapath #(.DATA_W(8), .NREGS(4)) dut_a (
    .clk(clk), .rst(rst), .load_reg(a_load_reg), .load_y(a_load_y), .load_pc(a_load_pc),
    .inc_pc(a_inc_pc), .load_ir(a_load_ir), .load_addr(a_load_addr), .load_flags(a_load_flags),
    .sel_bus_1(a_sel1), .sel_bus_2(a_sel2), .alu_op(a_op), .alu_start(a_start),
    .mem_word(a_mem), .bus_1(a_bus1), .instruction(a_instr), .address(a_addr), .pc(a_pc),
    .flags(a_flags), .alu_busy(a_busy), .alu_done(a_done)
  );

  param_datapath #(.DATA_W(16), .NREGS(8)) dut_w (
    .clk(clk), .rst(rst), .load_reg(w_load_reg), .load_y(w_load_y), .load_pc(w_load_pc),
    .inc_pc(w_inc_pc), .load_ir(w_load_ir), .load_addr(w_load_addr), .load_flags(w_load_flags),
    .sel_bus_1(w_sel1), .sel_bus_2(w_sel2), .alu_op(w_op), .alu_start(w_start),
    .mem_word(w_mem), .bus_1(w_bus1), .instruction(w_instr), .address(w_addr), .pc(w_pc),
    .flags(w_flags), .alu_busy(w_busy), .alu_done(w_done)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model of the 8-bit instance, kept as plain numbers.
  longint     m_reg [4];
  longint     m_y, m_pc, m_ir, m_addr, m_prod, m_ma, m_mb;
  logic [3:0] m_flags;
  int         m_left;
  bit         m_done;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 0;
    m_y = 0; m_pc = 0; m_ir = 0; m_addr = 0; m_prod = 0; m_ma = 0; m_mb = 0;
    m_flags = 4'h0; m_left = 0; m_done = 0;
  endtask

  function automatic longint bus1_ref(input int sel);
    if (sel < 4)  return m_reg[sel];
    if (sel == 4) return m_pc;
    return 0;
  endfunction

  function automatic longint sgn(input int w, input longint x);
    return (x >= (longint'(1) << (w - 1))) ? x - (longint'(1) << w) : x;
  endfunction

  // ALU rules from arithmetic: result, then {Z, N, C, V}.
  task automatic alu_ref(input int w, input longint a, input longint b, input int op,
                         input longint prod, output longint res, output logic [3:0] fl);
    longint mask, smax, smin, s;
    bit c, v;
    mask = (longint'(1) << w) - 1;
    smax = (longint'(1) << (w - 1)) - 1;
    smin = -(longint'(1) << (w - 1));
    c = 0; v = 0; res = 0;
    case (op)
      0: begin
        res = (a + b) & mask; c = (a + b) > mask;
        s = sgn(w, a) + sgn(w, b); v = (s > smax) || (s < smin);
      end
      1: begin
        res = (a - b) & mask; c = a < b;
        s = sgn(w, a) - sgn(w, b); v = (s > smax) || (s < smin);
      end
      2: res = a & b;
      3: res = (~a) & mask;
      4: begin res = prod & mask; c = (prod >> w) != 0; v = c; end
      5: res = a | b;
      6: res = a ^ b;
      7: begin res = (a << 1) & mask; c = ((a >> (w - 1)) & 1) != 0; end
      8: begin res = a >> 1; c = (a & 1) != 0; end
      default: res = 0;
    endcase
    fl = {res == 0, ((res >> (w - 1)) & 1) != 0, c, v};
  endtask

  task automatic idle_a();
    a_load_reg = 0; a_load_y = 0; a_load_pc = 0; a_inc_pc = 0; a_load_ir = 0;
    a_load_addr = 0; a_load_flags = 0; a_sel1 = 0; a_sel2 = 0; a_op = 0; a_start = 0; a_mem = 0;
  endtask

  task automatic idle_w();
    w_load_reg = 0; w_load_y = 0; w_load_pc = 0; w_inc_pc = 0; w_load_ir = 0;
    w_load_addr = 0; w_load_flags = 0; w_sel1 = 0; w_sel2 = 0; w_op = 0; w_start = 0; w_mem = 0;
  endtask

  task automatic check_a();
    chk("pc", a_pc, m_pc);
    chk("ir", a_instr, m_ir);
    chk("addr", a_addr, m_addr);
    chk("flags", a_flags, m_flags);
    chk("busy", a_busy, m_left > 0);
    chk("done", a_done, m_done);
    chk("bus_1", a_bus1, bus1_ref(int'(a_sel1)));
  endtask

  // One clock of the 8-bit instance with the currently driven inputs.
  task automatic step_a();
    longint b1, res, bus2;
    logic [3:0] fl;
    bit was_busy;
    b1 = bus1_ref(int'(a_sel1));
    alu_ref(8, m_y, b1, int'(a_op), m_prod, res, fl);
    case (a_sel2)
      2'd0:    bus2 = res;
      2'd1:    bus2 = b1;
      2'd2:    bus2 = longint'(a_mem);
      default: bus2 = 0;
    endcase
    was_busy = (m_left > 0);
    m_done = 0;
    if (was_busy) begin
      m_left--;
      if (m_left == 0) begin m_prod = m_ma * m_mb; m_done = 1; end
    end else if (a_start && a_op == 4'd4) begin
      m_ma = m_y; m_mb = b1; m_left = 8;
    end
    for (int i = 0; i < 4; i++) if (a_load_reg[i]) m_reg[i] = bus2;
    if (a_load_y) m_y = bus2;
    if (a_load_pc) m_pc = bus2;
    else if (a_inc_pc) m_pc = (m_pc + 1) % 256;
    if (a_load_ir) m_ir = bus2;
    if (a_load_addr) m_addr = bus2;
    if (a_load_flags && !was_busy) m_flags = fl;
    @(posedge clk);
    #1;
    check_a();
  endtask

  task automatic load_a(input logic [3:0] mask, input logic ly, input logic [7:0] val);
    idle_a();
    a_sel2 = 2'd2; a_mem = val; a_load_reg = mask; a_load_y = ly;
    step_a();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_a();
    idle_w();
    model_reset();
    rst = 1'b1;
    #3 rst = 1'b0;

    // Reset held with random strobes: everything stays zero.
    for (int i = 0; i < 5; i++) begin
      a_load_reg = 4'($urandom); a_load_y = 1; a_load_pc = 1; a_inc_pc = 1; a_load_ir = 1;
      a_load_addr = 1; a_load_flags = 1; a_sel1 = 3'($urandom); a_sel2 = 2'($urandom);
      a_op = 4'd4; a_start = 1; a_mem = 8'($urandom);
      w_load_reg = 8'($urandom); w_load_pc = 1; w_inc_pc = 1; w_sel1 = 4'($urandom);
      w_sel2 = 2'd2; w_mem = 16'($urandom); w_start = 1; w_op = 4'd4;
      tick();
      chk("rst_a", {a_bus1, a_instr, a_addr, a_pc, a_flags, a_busy, a_done}, 0);
      chk("rst_w", {w_bus1, w_instr, w_addr, w_pc, w_flags, w_busy, w_done}, 0);
    end
    idle_a();
    idle_w();
    rst = 1'b1;
    step_a();
    step_a();
    chk("rst_rel_w", {w_bus1, w_instr, w_addr, w_pc, w_flags, w_busy, w_done}, 0);

    // ADD with signed overflow.
    load_a(4'b0000, 1, 8'h7F);
    load_a(4'b0001, 0, 8'h01);
    idle_a(); a_sel1 = 0; a_op = 4'd0; a_load_flags = 1; a_load_reg = 4'b0010;
    step_a();
    chk("add_flags", a_flags, 4'h5);
    idle_a(); a_sel1 = 1; step_a();
    chk("add_res", a_bus1, 8'h80);

    // SUB with borrow, then SUB to zero.
    load_a(4'b0000, 1, 8'h03);
    load_a(4'b0001, 0, 8'h05);
    idle_a(); a_sel1 = 0; a_op = 4'd1; a_load_flags = 1; a_load_reg = 4'b0010;
    step_a();
    chk("sub_flags", a_flags, 4'h6);
    idle_a(); a_sel1 = 1; step_a();
    chk("sub_res", a_bus1, 8'hFE);
    load_a(4'b0000, 1, 8'h05);
    idle_a(); a_sel1 = 0; a_op = 4'd1; a_load_flags = 1;
    step_a();
    chk("sub_zero", a_flags, 4'h8);

    // MUL 0x12 x 0x10 with operand disturbance and a second start mid-run.
    load_a(4'b0000, 1, 8'h12);
    load_a(4'b0001, 0, 8'h10);
    idle_a(); a_sel1 = 0; a_op = 4'd4; a_start = 1;
    step_a();
    chk("mul_busy_start", a_busy, 1);
    for (int i = 1; i < 8; i++) begin
      idle_a(); a_op = 4'd4; a_sel1 = 0;
      if (i == 2) begin a_sel2 = 2'd2; a_mem = 8'h55; a_load_y = 1; end
      if (i == 3) a_start = 1;
      if (i == 4) begin a_sel2 = 2'd2; a_mem = 8'h99; a_load_reg = 4'b0001; a_load_flags = 1; end
      step_a();
      chk("mul_busy_run", {a_busy, a_done}, 2'b10);
    end
    idle_a(); step_a();
    chk("mul_done", {a_busy, a_done}, 2'b01);
    idle_a(); a_op = 4'd4; a_load_reg = 4'b0100; a_load_flags = 1;
    step_a();
    chk("mul_done_pulse", a_done, 0);
    chk("mul_flags", a_flags, 4'h3);
    idle_a(); a_sel1 = 2; step_a();
    chk("mul_res", a_bus1, 8'h20);

    // MUL 0x0F x 0x03 without high half.
    load_a(4'b0000, 1, 8'h0F);
    load_a(4'b0001, 0, 8'h03);
    idle_a(); a_sel1 = 0; a_op = 4'd4; a_start = 1;
    step_a();
    for (int i = 0; i < 8; i++) begin idle_a(); a_op = 4'd4; step_a(); end
    chk("mul2_done", a_done, 1);
    idle_a(); a_op = 4'd4; a_load_reg = 4'b0100; a_load_flags = 1;
    step_a();
    chk("mul2_flags", a_flags, 4'h0);
    idle_a(); a_sel1 = 2; step_a();
    chk("mul2_res", a_bus1, 8'h2D);

    // PC: load beats increment, increment wraps.
    idle_a(); a_sel2 = 2'd2; a_mem = 8'hFF; a_load_pc = 1; a_inc_pc = 1;
    step_a();
    chk("pc_prio", a_pc, 8'hFF);
    idle_a(); a_inc_pc = 1; step_a();
    chk("pc_wrap", a_pc, 8'h00);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      a_load_reg   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      a_load_y     = ($urandom_range(0, 3) == 0);
      a_load_pc    = ($urandom_range(0, 7) == 0);
      a_inc_pc     = ($urandom_range(0, 1) == 0);
      a_load_ir    = ($urandom_range(0, 3) == 0);
      a_load_addr  = ($urandom_range(0, 3) == 0);
      a_load_flags = ($urandom_range(0, 1) == 0);
      a_sel1       = 3'($urandom);
      a_sel2       = 2'($urandom);
      a_op         = ($urandom_range(0, 3) == 0) ? 4'd4 : 4'($urandom_range(0, 11));
      a_start      = ($urandom_range(0, 2) == 0);
      a_mem        = 8'($urandom);
      step_a();
    end

    // Reset in the third RUN cycle aborts the multiply and clears the product.
    load_a(4'b0000, 1, 8'hE7);
    load_a(4'b0001, 0, 8'hC3);
    idle_a(); a_op = 4'd4; a_start = 1; step_a();
    idle_a(); step_a();
    step_a();
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", a_busy, 0);
    chk("rst_mid_done", a_done, 0);
    model_reset();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step_a();
    idle_a(); a_op = 4'd4; a_load_reg = 4'b0001; a_sel1 = 1; step_a();
    idle_a(); a_sel1 = 0; step_a();
    chk("rst_mid_res", a_bus1, 0);

    // Wide instance: register file, PC on bus_1, unused selects, SHL carry.
    idle_a();
    for (int i = 0; i < 8; i++) begin
      idle_w(); w_sel2 = 2'd2; w_mem = 16'hA5C0 + 16'(i * 16'h0103); w_load_reg = 8'(1 << i);
      tick();
    end
    for (int i = 0; i < 8; i++) begin
      idle_w(); w_sel1 = 4'(i); #1;
      chk($sformatf("wide_r%0d", i), w_bus1, 16'hA5C0 + 16'(i * 16'h0103));
    end
    idle_w(); w_sel2 = 2'd2; w_mem = 16'h1234; w_load_pc = 1; tick();
    idle_w(); w_sel1 = 4'd8; #1;
    chk("wide_pc", w_bus1, 16'h1234);
    for (int s = 9; s < 16; s++) begin
      w_sel1 = 4'(s); #1;
      chk($sformatf("wide_sel%0d", s), w_bus1, 0);
    end
    idle_w(); w_sel2 = 2'd2; w_mem = 16'hFFFF; w_load_y = 1; tick();
    idle_w(); w_op = 4'd7; w_load_reg = 8'h01; w_load_flags = 1; tick();
    chk("wide_shl_flags", w_flags, 4'h6);
    idle_w(); w_sel1 = 0; #1;
    chk("wide_shl_res", w_bus1, 16'hFFFE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
